// File: rtl/shreg_pkg.sv
// shreg_pkg - shared definitions for the shift_reg_async slice.
//   Mode encodings for the manual-operation mux and the burst FSM state
//   encoding. Imported by shreg_ctrl and shift_reg_async.
package shreg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shreg_ctrl.sv
// shreg_ctrl - burst serialiser controller.
//   Sequences a WIDTH-cycle serial transfer and flags when the datapath
//   must parallel-load or shift.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_start  request a burst (honoured only in IDLE)
//   o_load   datapath loads pin this edge (start accepted)
//   o_run    datapath shifts left from sin this edge (burst active)
//   o_busy   FSM is in RUN
//   o_done   registered one-cycle pulse after the last burst edge
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | manual ops allowed; start launches a burst
// RUN   | burst shifting; cnt counts remaining edges down to 0
module shreg_ctrl
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    output logic o_load,
    output logic o_run,
    output logic o_busy,
    output logic o_done
);

    localparam int CW = $clog2(WIDTH);

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic            w_last;

    assign w_last = (r_state == RUN) && (r_cnt == '0);

    // State register, counter and done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
            if (r_state == IDLE && i_start) begin
                r_cnt <= CW'(WIDTH - 1);
            end else if (r_state == RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Next-state logic; start is not queued while running.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN:     if (w_last)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        o_load = 1'b0;
        o_run  = 1'b0;
        o_busy = 1'b0;
        case (r_state)
            IDLE:    o_load = i_start;
            RUN: begin
                o_run  = 1'b1;
                o_busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_done = r_done;

endmodule

// File: rtl/shift_reg_async.sv
// shift_reg_async - WIDTH-bit shift register with async active-low reset,
//   manual hold/shift-left/shift-right/load modes and an autonomous
//   WIDTH-cycle MSB-first burst serialiser.
// Optional feature macro: SHREG_ROTATE_EN adds i_rot, turning manual
//   shifts into rotates (sin ignored) when i_rot=1.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_en     enable manual op (ignored while busy)
//   i_mode   00 hold, 01 shift left, 10 shift right, 11 load
//   i_sin    serial input
//   i_pin    parallel load data
//   i_start  start a burst
//   i_rot    rotate select (SHREG_ROTATE_EN only)
//   o_q      register contents
//   o_sout   serial out, always q[WIDTH-1]
//   o_busy   burst in progress
//   o_done   one-cycle pulse at end of burst
module shift_reg_async
    import shreg_pkg::*;
#(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_sin,
    input  logic [WIDTH-1:0] i_pin,
    input  logic             i_start,
`ifdef SHREG_ROTATE_EN
    input  logic             i_rot,
`endif
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_load;
    logic             w_run;
    logic             w_fill_l;   // bit entering at LSB on a left shift
    logic             w_fill_r;   // bit entering at MSB on a right shift

    shreg_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .o_load  (w_load),
        .o_run   (w_run),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

`ifdef SHREG_ROTATE_EN
    assign w_fill_l = i_rot ? r_q[WIDTH-1] : i_sin;
    assign w_fill_r = i_rot ? r_q[0]       : i_sin;
`else
    assign w_fill_l = i_sin;
    assign w_fill_r = i_sin;
`endif

    // Start beats the manual mux; the burst always fills from sin.
    always_comb begin
        w_q_next = r_q;
        if (w_load) begin
            w_q_next = i_pin;
        end else if (w_run) begin
            w_q_next = {r_q[WIDTH-2:0], i_sin};
        end else if (i_en) begin
            case (i_mode)
                MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], w_fill_l};
                MODE_SHR:  w_q_next = {w_fill_r, r_q[WIDTH-1:1]};
                MODE_LOAD: w_q_next = i_pin;
                default:   w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign o_q    = r_q;
    assign o_sout = r_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_async.sv
module tb_shift_reg_async;

    localparam int         W    = 8;
    localparam logic [7:0] RVAL = 8'hA5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic         sin;
    logic [7:0]   pin;
    logic         start;
    logic         rot;
    logic [7:0]   q;
    logic         sout;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt;
    int busy_cnt;

    logic [7:0] sin_stream;
    logic [7:0] sout_exp;

    always #5 clk = ~clk;

    shift_reg_async #(.WIDTH(W), .RST_VAL(RVAL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_mode  (mode),
        .i_sin   (sin),
        .i_pin   (pin),
        .i_start (start),
`ifdef SHREG_ROTATE_EN
        .i_rot   (rot),
`endif
        .o_q     (q),
        .o_sout  (sout),
        .o_busy  (busy),
        .o_done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 2'b00; sin = 1'b0;
        pin = 8'h00; start = 1'b0; rot = 1'b0;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("por_q", q, RVAL);
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual ops: load, shift left, shift right, hold
        en = 1'b1; mode = 2'b11; pin = 8'h3C;
        @(negedge clk);
        chk("load", q, 8'h3C);
        mode = 2'b01; sin = 1'b1;
        @(negedge clk);
        chk("shl", q, 8'h79);
        chk("sout_shl", sout, 0);
        mode = 2'b10; sin = 1'b0;
        @(negedge clk);
        chk("shr", q, 8'h3C);
        en = 1'b0; mode = 2'b01; sin = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_en0", q, 8'h3C);
        en = 1'b1; mode = 2'b00;
        @(negedge clk);
        chk("hold_mode0", q, 8'h3C);
        en = 1'b0;

        // Async reset between edges, no clock needed
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", q, RVAL);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Burst: pin=C3, sin stream 1,0,1,1,0,0,1,0; start beats en/mode
        sin_stream = 8'b10110010;
        sout_exp   = 8'hC3;
        pin = 8'hC3; start = 1'b1; en = 1'b1; mode = 2'b10; sin = 1'b1;
        @(negedge clk);
        start = 1'b0; en = 1'b1; mode = 2'b11; pin = 8'h00;
        chk("burst_first_q", q, 8'hC3);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst_busy%0d", i), busy, 1);
            chk($sformatf("burst_sout%0d", i), sout, sout_exp[7-i]);
            chk($sformatf("burst_done%0d", i), done, 0);
            sin = sin_stream[7-i];
            @(negedge clk);
        end
        en = 1'b0;
        chk("burst_end_busy", busy, 0);
        chk("burst_end_done", done, 1);
        chk("burst_end_q", q, 8'hB2);
        @(negedge clk);
        chk("burst_done_clear", done, 0);
        chk("burst_idle_q", q, 8'hB2);

        // Start while busy is ignored
        pin = 8'h5A; sin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            start = (i == 3);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_restart_len", busy_cnt, 8);
        chk("busy_restart_dones", done_cnt, 1);
        chk("busy_restart_q", q, 8'h00);

        // Reset mid-burst
        pin = 8'hF0; sin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_q", q, RVAL);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_q_after", q, RVAL);

        // Fresh burst after abort
        pin = 8'h96; sin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fresh_busy", busy, 1);
        chk("fresh_sout", sout, 1);
        repeat (8) @(negedge clk);
        chk("fresh_done", done, 1);
        chk("fresh_q", q, 8'h00);

`ifdef SHREG_ROTATE_EN
        en = 1'b1; mode = 2'b11; pin = 8'h81; rot = 1'b1;
        @(negedge clk);
        mode = 2'b01; sin = 1'b0;
        @(negedge clk);
        chk("rotl", q, 8'h03);
        mode = 2'b11;
        @(negedge clk);
        mode = 2'b10; sin = 1'b0;
        @(negedge clk);
        chk("rotr", q, 8'hC0);
        rot = 1'b0; mode = 2'b01; sin = 1'b0;
        @(negedge clk);
        chk("rot0_shl", q, 8'h80);
        en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_async.md
# shift_reg_async

Parametrised shift register with asynchronous active-low reset and a burst serialiser. It is the next-generation storage element after the single-bit async-reset D flip-flop: a WIDTH-bit register with hold, shift-left, shift-right and parallel-load modes. A small FSM adds an autonomous WIDTH-cycle serial transfer that shifts a word out MSB-first while capturing a word in. It serves as the general-purpose SISO/SIPO/PISO building block for the serial-link and test exercises.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32
- RST_VAL, 0, value q takes on reset (WIDTH bits)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  enables the manual mode operation; ignored while busy
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
- sin  input  1  serial input bit
- pin  input  WIDTH  parallel load data
- start  input  1  begins a burst transfer when sampled high in IDLE
- q  output  WIDTH  register contents
- sout  output  1  serial output, combinational, always q[WIDTH-1]
- busy  output  1  high while the FSM is in RUN
- done  output  1  one-cycle registered pulse at the end of a burst
- rot  input  1  rotate select; present only with SHREG_ROTATE_EN

## Operation
- Reset is asynchronous and active-low. It applies immediately with no clock edge needed: q=RST_VAL, state=IDLE, cnt=0, busy=0, done=0.
- FSM states:
  - IDLE: manual ops.
  - RUN: burst; manual inputs ignored.
- IDLE, start=1: q<=pin, cnt<=WIDTH-1, go to RUN. start has priority over en/mode on the same edge.
- IDLE, start=0, en=1, by mode:
  - 01: q<={q[WIDTH-2:0],sin}.
  - 10: q<={sin,q[WIDTH-1:1]}.
  - 11: q<=pin.
  - 00: q held.
- IDLE, en=0: q held.
- RUN, every edge: q<={q[WIDTH-2:0],sin}.
  - If cnt==0: go to IDLE, done<=1.
  - Otherwise: cnt<=cnt-1.
- start while busy is ignored; it is not queued.
- done is high for exactly one cycle and is 0 on every other edge.
- cnt is $clog2(WIDTH) bits wide; it never underflows.

## Timing
- Manual ops: q updates on the same edge that samples en/mode. Latency is 1 cycle.
- Burst from a start sampled at edge E0:
  - busy is high from after E0 until after E0+WIDTH, i.e. WIDTH cycles.
  - sout presents pin[WIDTH-1], pin[WIDTH-2] … pin[0] across those WIDTH cycles, one bit per cycle.
  - sin is sampled at edges E0+1 … E0+WIDTH. The first bit sampled lands in q[WIDTH-1] after the final edge.
  - done is high in the cycle after E0+WIDTH, coincident with busy=0.
  - A new start may be sampled at edge E0+WIDTH+1, so back-to-back bursts have 1 idle cycle between them.
- Reset asserted mid-burst aborts the burst: busy=0, no done pulse, q=RST_VAL.

## Configuration
- SHREG_ROTATE_EN defined:
  - The rot port exists.
  - In IDLE with en=1, rot=1 and mode 01/10, the shift rotates: q<={q[WIDTH-2:0],q[WIDTH-1]} or {q[0],q[WIDTH-1:1]}; sin is ignored.
  - rot has no effect in RUN or for modes 00/11.
- SHREG_ROTATE_EN undefined: the rot port is absent and shifts always fill from sin.

## Structure
- Shared package shreg_pkg holds:
  - Mode localparams MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11.
  - FSM state encoding IDLE=0, RUN=1.
- One sub-module, shreg_ctrl, holds the FSM, cnt, busy and done. It outputs a run strobe; the top module holds the q datapath and the mode mux.

## Test plan
- Reset: with WIDTH=8 and RST_VAL=8'hA5, assert reset low between clock edges → q=8'hA5, busy=0, done=0 immediately, before the next edge.
- Manual ops: load 8'h3C, then shift left with sin=1 → q=8'h79; then shift right with sin=0 → q=8'h3C; then en=0 for 3 edges → q holds 8'h3C.
- Burst: pin=8'hC3, sin stream 1,0,1,1,0,0,1,0 → sout shows 1,1,0,0,0,0,1,1 over 8 busy cycles; done pulses once; final q=8'hB2.
- Start while busy: pulse start again at the 4th burst cycle → burst length stays 8 and only one done pulse occurs.
- Reset mid-burst: assert reset at the 5th burst cycle → busy=0 immediately, no done pulse; after release q=RST_VAL and a fresh start works.
- Rotate (SHREG_ROTATE_EN defined): q=8'h81, rot=1, mode 01 → q=8'h03; mode 10 from 8'h81 → q=8'hC0.
